// File: rtl/pim_pkg.sv
// pim_pkg: shared types and default sizing for the PIM command scheduler
package pim_pkg;
  localparam int PIM_NUM_REQ = 4;
  localparam int PIM_LEN = 10;
  localparam int PIM_SIZE_W = 5;
  localparam int PIM_ID_W = $clog2(PIM_NUM_REQ);
  localparam int PIM_MEM_ELEMENTS = 1024;
  localparam int PIM_MAX_MATRIX_SIZE = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMPLETE} sched_state_t;
  typedef struct packed {
    logic [PIM_LEN-1:0] src1;
    logic [PIM_LEN-1:0] src2;
    logic [PIM_LEN-1:0] dst;
    logic [PIM_SIZE_W-1:0] size;
    logic [PIM_ID_W-1:0] id;
    logic err;
  } cmd_t;
endpackage

// File: rtl/pim_rr_arbiter.sv
// pim_rr_arbiter: round-robin one-hot grant starting at a rotating pointer
module pim_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);
  localparam logic [NUM_REQ-1:0] ONE = 1;
  logic [IW-1:0] ptr;
  logic [IW-1:0] j;
  logic found;
  // first valid requester at or after the pointer, wrapping
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
    grant = (en && found) ? ONE << idx : '0;
  end
  // pointer moves past the winner only on a completed handshake
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= '0;
    else if (en && found) ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
endmodule

// File: rtl/pim_cmd_scheduler.sv
// pim_cmd_scheduler: arbitrates matmul commands into a FIFO and sequences the shared PIM engine
module pim_cmd_scheduler import pim_pkg::*; #(
  parameter int NUM_REQ = PIM_NUM_REQ,
  parameter int LEN = PIM_LEN,
  parameter int MEM_ELEMENTS = PIM_MEM_ELEMENTS,
  parameter int MAX_MATRIX_SIZE = PIM_MAX_MATRIX_SIZE,
  parameter int SIZE_W = PIM_SIZE_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int ID_W = $clog2(NUM_REQ),
  localparam int QW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*LEN-1:0]  req_src1_addr,
  input  logic [NUM_REQ*LEN-1:0]  req_src2_addr,
  input  logic [NUM_REQ*LEN-1:0]  req_dst_addr,
  input  logic [NUM_REQ*SIZE_W-1:0] req_size,
  output logic                    eng_start,
  output logic [LEN-1:0]          eng_src1_addr,
  output logic [LEN-1:0]          eng_src2_addr,
  output logic [LEN-1:0]          eng_dst_addr,
  output logic [SIZE_W-1:0]       eng_size,
  input  logic                    eng_done,
  output logic                    eng_abort,
  output logic                    cpl_valid,
  output logic [ID_W-1:0]         cpl_id,
  output logic                    cpl_err,
  output logic                    busy,
  output logic [QW-1:0]           queue_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam int W = LEN + 2 * SIZE_W;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0] gidx;
  logic accept, pop, full;
  logic [LEN-1:0] sel_src1, sel_src2, sel_dst;
  logic [SIZE_W-1:0] sel_size;
  logic [W-1:0] area;
  cmd_t in_cmd, head, cmd;
  cmd_t fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [QW-1:0] level;
  sched_state_t state;
  logic [CW-1:0] ctr;

  pim_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req_valid),
    .en(rst && !full),
    .grant(grant),
    .idx(gidx)
  );

  assign full = level == QW'(FIFO_DEPTH);
  assign accept = |grant;
  assign req_ready = grant;
  assign pop = state == IDLE && level != '0;
  assign head = fifo_q[rp];
  assign sel_src1 = req_src1_addr[gidx*LEN +: LEN];
  assign sel_src2 = req_src2_addr[gidx*LEN +: LEN];
  assign sel_dst = req_dst_addr[gidx*LEN +: LEN];
  assign sel_size = req_size[gidx*SIZE_W +: SIZE_W];
  assign eng_src1_addr = cmd.src1;
  assign eng_src2_addr = cmd.src2;
  assign eng_dst_addr = cmd.dst;
  assign eng_size = cmd.size;
  assign busy = state != IDLE || level != '0;
  assign queue_level = level;

  // range check at accept, evaluated wide enough that base+N*N cannot wrap
  always_comb begin
    area = W'(sel_size) * W'(sel_size);
    in_cmd.src1 = sel_src1;
    in_cmd.src2 = sel_src2;
    in_cmd.dst = sel_dst;
    in_cmd.size = sel_size;
    in_cmd.id = gidx;
    in_cmd.err = sel_size == '0 || sel_size > SIZE_W'(MAX_MATRIX_SIZE) ||
                 W'(sel_src1) + area > W'(MEM_ELEMENTS) ||
                 W'(sel_src2) + area > W'(MEM_ELEMENTS) ||
                 W'(sel_dst) + area > W'(MEM_ELEMENTS);
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk)
    if (accept) fifo_q[wp] <= in_cmd;

  // FIFO pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (accept) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level <= level + QW'(accept) - QW'(pop);
    end

  // engine sequencing with registered one-cycle pulses and the hang timeout
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cmd <= '0;
      ctr <= '0;
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      cpl_valid <= 1'b0;
      cpl_id <= '0;
      cpl_err <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      cpl_valid <= 1'b0;
      cpl_id <= '0;
      cpl_err <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          cmd <= head;
          state <= head.err ? COMPLETE : ISSUE;
          eng_start <= !head.err;
          cpl_valid <= head.err;
          cpl_id <= head.err ? head.id : '0;
          cpl_err <= head.err;
        end
        ISSUE: begin
          state <= WAIT;
          ctr <= '0;
        end
        WAIT: if (eng_done) begin
          state <= COMPLETE;
          cpl_valid <= 1'b1;
          cpl_id <= cmd.id;
          cpl_err <= cmd.err;
        end else if (ctr == CW'(TIMEOUT_CYCLES - 1)) begin
          state <= COMPLETE;
          eng_abort <= 1'b1;
          cpl_valid <= 1'b1;
          cpl_id <= cmd.id;
          cpl_err <= 1'b1;
        end else ctr <= ctr + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pim_cmd_scheduler.sv
// tb_pim_cmd_scheduler: directed scenario tests for the PIM command scheduler
module tb_pim_cmd_scheduler;
  localparam int N = 4;
  localparam int LEN = 10;
  localparam int SW = 5;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*LEN-1:0] req_src1_addr = '0, req_src2_addr = '0, req_dst_addr = '0;
  logic [N*SW-1:0] req_size = '0;
  logic eng_start, eng_abort, cpl_valid, cpl_err, busy;
  logic eng_done = 1'b0;
  logic [LEN-1:0] eng_src1_addr, eng_src2_addr, eng_dst_addr;
  logic [SW-1:0] eng_size;
  logic [1:0] cpl_id;
  logic [2:0] queue_level;
  int checks = 0;
  int errors = 0;
  int acc_n = 0, cpl_n = 0, start_cnt = 0, abort_cnt = 0;
  int acc_log [64];
  logic [1:0] cpl_ids [64];
  logic cpl_errs [64];

  always #5 clk = ~clk;

  pim_cmd_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_src1_addr(req_src1_addr), .req_src2_addr(req_src2_addr),
    .req_dst_addr(req_dst_addr), .req_size(req_size),
    .eng_start(eng_start), .eng_src1_addr(eng_src1_addr), .eng_src2_addr(eng_src2_addr),
    .eng_dst_addr(eng_dst_addr), .eng_size(eng_size), .eng_done(eng_done),
    .eng_abort(eng_abort), .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_err(cpl_err),
    .busy(busy), .queue_level(queue_level)
  );

  always @(negedge clk) begin
    #2;
    if (|(req_valid & req_ready) && acc_n < 64) begin
      for (int i = 0; i < N; i++) if (req_ready[i]) acc_log[acc_n] = i;
      acc_n++;
    end
    if (cpl_valid && cpl_n < 64) begin
      cpl_ids[cpl_n] = cpl_id;
      cpl_errs[cpl_n] = cpl_err;
      cpl_n++;
    end
    if (eng_start) start_cnt++;
    if (eng_abort) abort_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cmd(input int i, input logic [9:0] s1, input logic [9:0] s2,
                         input logic [9:0] d, input logic [4:0] sz);
    req_src1_addr[i*LEN +: LEN] = s1;
    req_src2_addr[i*LEN +: LEN] = s2;
    req_dst_addr[i*LEN +: LEN] = d;
    req_size[i*SW +: SW] = sz;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req_valid = '0;
    eng_done = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_done();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (eng_start) ok = 1'b1;
      else tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_start got no eng_start within 64 cycles");
    end
  endtask

  task automatic wait_cpl(input int target);
    int k;
    k = 0;
    while (cpl_n < target && k < 300) begin
      tick();
      k++;
    end
    checks++;
    if (cpl_n < target) begin
      errors++;
      $display("FAIL wait_cpl got %0d completions exp %0d", cpl_n, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '1;
    repeat (2) tick();
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready got %b exp 0000", req_ready);
    end
    checks++;
    if ({eng_start, eng_abort, cpl_valid, cpl_err, busy, cpl_id, queue_level} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outs got %b%b%b%b%b id=%0d lvl=%0d exp all 0",
               eng_start, eng_abort, cpl_valid, cpl_err, busy, cpl_id, queue_level);
    end
    checks++;
    if ({eng_src1_addr, eng_src2_addr, eng_dst_addr, eng_size} !== 35'd0) begin
      errors++;
      $display("FAIL reset_eng_addr got %h %h %h %0d exp 0", eng_src1_addr, eng_src2_addr, eng_dst_addr, eng_size);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_rr_ptr got %b exp 0001", req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    set_cmd(0, 10'h000, 10'h040, 10'h080, 5'd8);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready got %b exp 0001", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if ({queue_level, eng_start, busy} !== {3'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_t1 got lvl=%0d start=%b busy=%b exp 1 0 1", queue_level, eng_start, busy);
    end
    tick();
    checks++;
    if (eng_start !== 1'b1) begin
      errors++;
      $display("FAIL single_start_t2 got %b exp 1", eng_start);
    end
    checks++;
    if ({eng_src1_addr, eng_src2_addr, eng_dst_addr, eng_size} !== {10'h000, 10'h040, 10'h080, 5'd8}) begin
      errors++;
      $display("FAIL single_eng_fields got %h %h %h %0d exp 000 040 080 8", eng_src1_addr, eng_src2_addr, eng_dst_addr, eng_size);
    end
    tick();
    checks++;
    if ({eng_start, eng_src1_addr, eng_src2_addr, eng_dst_addr, eng_size} !== {1'b0, 10'h000, 10'h040, 10'h080, 5'd8}) begin
      errors++;
      $display("FAIL single_stable got start=%b %h %h %h %0d exp 0 000 040 080 8", eng_start, eng_src1_addr, eng_src2_addr, eng_dst_addr, eng_size);
    end
    repeat (18) tick();
    checks++;
    if ({cpl_valid, eng_abort, eng_size} !== {1'b0, 1'b0, 5'd8}) begin
      errors++;
      $display("FAIL single_waiting got cpl=%b abort=%b size=%0d exp 0 0 8", cpl_valid, eng_abort, eng_size);
    end
    pulse_done();
    checks++;
    if ({cpl_valid, cpl_id, cpl_err} !== {1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL single_cpl got v=%b id=%0d err=%b exp 1 0 0", cpl_valid, cpl_id, cpl_err);
    end
    tick();
    checks++;
    if ({cpl_valid, cpl_id, cpl_err, busy} !== 5'd0) begin
      errors++;
      $display("FAIL single_after got v=%b id=%0d err=%b busy=%b exp 0", cpl_valid, cpl_id, cpl_err, busy);
    end
  endtask

  task automatic test_back_to_back();
    int a0, c0, s0, k;
    bit ok;
    apply_reset();
    a0 = acc_n;
    c0 = cpl_n;
    s0 = start_cnt;
    for (int i = 0; i < N; i++)
      set_cmd(i, 10'h100 + 10'(i * 16), 10'h200 + 10'(i * 16), 10'h300 + 10'(i * 4), 5'd2);
    req_valid = '1;
    k = 0;
    while (queue_level != 3'd4 && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (queue_level !== 3'd4) begin
      errors++;
      $display("FAIL b2b_fill got lvl=%0d exp 4", queue_level);
    end
    repeat (2) begin
      #1;
      checks++;
      if ({req_ready, queue_level} !== {4'b0000, 3'd4}) begin
        errors++;
        $display("FAIL b2b_full_ready got %b lvl=%0d exp 0000 4", req_ready, queue_level);
      end
      tick();
    end
    req_valid = '0;
    tick();
    checks++;
    if (acc_n - a0 != 5) begin
      errors++;
      $display("FAIL b2b_acc_count got %0d exp 5", acc_n - a0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (acc_log[a0 + i] != i % 4) begin
        errors++;
        $display("FAIL b2b_acc_order[%0d] got %0d exp %0d", i, acc_log[a0 + i], i % 4);
      end
    end
    checks++;
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL b2b_one_start got %0d exp 1", start_cnt - s0);
    end
    pulse_done();
    for (int i = 1; i < 5; i++) begin
      wait_start(ok);
      if (ok) begin
        checks++;
        if (eng_src1_addr !== 10'h100 + 10'((i % 4) * 16)) begin
          errors++;
          $display("FAIL b2b_issue_src1[%0d] got %h exp %h", i, eng_src1_addr, 10'h100 + 10'((i % 4) * 16));
        end
        repeat (4) tick();
        pulse_done();
      end
    end
    wait_cpl(c0 + 5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({cpl_ids[c0 + i], cpl_errs[c0 + i]} !== {2'(i % 4), 1'b0}) begin
        errors++;
        $display("FAIL b2b_cpl[%0d] got id=%0d err=%b exp id=%0d err=0", i, cpl_ids[c0 + i], cpl_errs[c0 + i], i % 4);
      end
    end
  endtask

  task automatic test_range();
    int c0, s0;
    bit ok;
    logic [3:0] exp_err;
    exp_err = 4'b1011;
    apply_reset();
    c0 = cpl_n;
    s0 = start_cnt;
    req_valid = 4'b0001;
    set_cmd(0, 10'h000, 10'h000, 10'h100, 5'd0);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL range_ready got %b exp 0001", req_ready);
    end
    tick();
    set_cmd(0, 10'h000, 10'h000, 10'h100, 5'd17);
    tick();
    set_cmd(0, 10'h3F0, 10'h000, 10'h100, 5'd4);
    tick();
    set_cmd(0, 10'h3F0, 10'h000, 10'h100, 5'd5);
    tick();
    req_valid = '0;
    wait_start(ok);
    if (ok) begin
      checks++;
      if ({eng_src1_addr, eng_size} !== {10'h3F0, 5'd4}) begin
        errors++;
        $display("FAIL range_legal_issue got %h %0d exp 3f0 4", eng_src1_addr, eng_size);
      end
      repeat (2) tick();
      pulse_done();
    end
    wait_cpl(c0 + 4);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({cpl_ids[c0 + i], cpl_errs[c0 + i]} !== {2'd0, exp_err[i]}) begin
        errors++;
        $display("FAIL range_cpl[%0d] got id=%0d err=%b exp id=0 err=%b", i, cpl_ids[c0 + i], cpl_errs[c0 + i], exp_err[i]);
      end
    end
    checks++;
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL range_start_count got %0d exp 1", start_cnt - s0);
    end
  endtask

  task automatic test_timeout();
    int k;
    bit ok;
    apply_reset();
    set_cmd(1, 10'h010, 10'h050, 10'h090, 5'd2);
    req_valid = 4'b0010;
    tick();
    set_cmd(2, 10'h020, 10'h060, 10'h0A0, 5'd2);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    wait_start(ok);
    checks++;
    if (eng_src1_addr !== 10'h010) begin
      errors++;
      $display("FAIL tmo_first_src1 got %h exp 010", eng_src1_addr);
    end
    k = 0;
    while (!eng_abort && k < 5000) begin
      tick();
      k++;
    end
    checks++;
    if (k != 4097) begin
      errors++;
      $display("FAIL tmo_abort_delay got %0d exp 4097", k);
    end
    checks++;
    if ({eng_abort, cpl_valid, cpl_err, cpl_id} !== {1'b1, 1'b1, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL tmo_cpl got abort=%b v=%b err=%b id=%0d exp 1 1 1 1", eng_abort, cpl_valid, cpl_err, cpl_id);
    end
    tick();
    checks++;
    if ({eng_abort, cpl_valid} !== 2'b00) begin
      errors++;
      $display("FAIL tmo_pulse_width got abort=%b v=%b exp 0 0", eng_abort, cpl_valid);
    end
    wait_start(ok);
    checks++;
    if (eng_src1_addr !== 10'h020) begin
      errors++;
      $display("FAIL tmo_next_src1 got %h exp 020", eng_src1_addr);
    end
    tick();
    pulse_done();
    checks++;
    if ({cpl_valid, cpl_err, cpl_id} !== {1'b1, 1'b0, 2'd2}) begin
      errors++;
      $display("FAIL tmo_next_cpl got v=%b err=%b id=%0d exp 1 0 2", cpl_valid, cpl_err, cpl_id);
    end
  endtask

  task automatic test_done_vs_timeout();
    int c0, s0, ab0;
    bit ok;
    apply_reset();
    set_cmd(3, 10'h200, 10'h210, 10'h220, 5'd4);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    wait_start(ok);
    ab0 = abort_cnt;
    repeat (4096) tick();
    pulse_done();
    checks++;
    if ({eng_abort, cpl_valid, cpl_err, cpl_id} !== {1'b0, 1'b1, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL tie_cpl got abort=%b v=%b err=%b id=%0d exp 0 1 0 3", eng_abort, cpl_valid, cpl_err, cpl_id);
    end
    repeat (2) tick();
    c0 = cpl_n;
    s0 = start_cnt;
    pulse_done();
    repeat (3) tick();
    checks++;
    if (cpl_n != c0 || start_cnt != s0 || abort_cnt != ab0) begin
      errors++;
      $display("FAIL stray_done got cpl+%0d start+%0d abort+%0d exp 0 0 0", cpl_n - c0, start_cnt - s0, abort_cnt - ab0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int c0, s0, ab0;
    apply_reset();
    set_cmd(0, 10'h100, 10'h110, 10'h120, 5'd3);
    req_valid = 4'b0001;
    repeat (4) tick();
    req_valid = '0;
    checks++;
    if ({queue_level, busy} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL rmid_queued got lvl=%0d busy=%b exp 3 1", queue_level, busy);
    end
    tick();
    checks++;
    if (eng_src1_addr !== 10'h100) begin
      errors++;
      $display("FAIL rmid_inflight got %h exp 100", eng_src1_addr);
    end
    c0 = cpl_n;
    s0 = start_cnt;
    ab0 = abort_cnt;
    rst = 1'b0;
    #1;
    checks++;
    if ({queue_level, busy, eng_start, eng_abort, cpl_valid, cpl_err, cpl_id} !== 10'd0) begin
      errors++;
      $display("FAIL rmid_outs got lvl=%0d busy=%b start=%b abort=%b v=%b exp 0", queue_level, busy, eng_start, eng_abort, cpl_valid);
    end
    checks++;
    if ({eng_src1_addr, eng_size} !== 15'd0) begin
      errors++;
      $display("FAIL rmid_eng got %h %0d exp 0 0", eng_src1_addr, eng_size);
    end
    repeat (2) tick();
    rst = 1'b1;
    repeat (20) tick();
    checks++;
    if (cpl_n != c0 || start_cnt != s0 || abort_cnt != ab0 || queue_level !== 3'd0) begin
      errors++;
      $display("FAIL rmid_after got cpl+%0d start+%0d abort+%0d lvl=%0d exp 0 0 0 0", cpl_n - c0, start_cnt - s0, abort_cnt - ab0, queue_level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_range();
    test_timeout();
    test_done_vs_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
